// File: rtl/rf_wb_sched_pkg.sv
// Shared constants for the register-file writeback scheduler.
package rf_wb_sched_pkg;

  localparam int DEF_DW  = 16;
  localparam int DEF_AW  = 4;
  localparam int REG_CNT = 2 ** DEF_AW;

  // Source indices, also used as round-robin pointer values.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry holding slot for a writeback source with valid/ready handshake.
module rf_wb_slot
  import rf_wb_sched_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          grant,
  output logic          ready,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  // A granted slot drains this edge, so it can take a new entry at the same time.
  assign ready = !full || grant;

  // Slot contents: load on handshake, otherwise empty out when granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      addr <= {AW{1'b0}};
      data <= {DW{1'b0}};
    end else if (in_valid && ready) begin
      full <= 1'b1;
      addr <= in_addr;
      data <= in_data;
    end else if (grant) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler: arbitrates ALU and load results onto the single RF
// write port and keeps a pending-write scoreboard for issue hazard checks.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [AW-1:0]      alu_addr,
  input  logic [DW-1:0]      alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_data,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  output logic               rsv_conflict,
  output logic [2**AW-1:0]   busy,
  output logic               rf_wen,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata
);

  localparam int RC = 2 ** AW;

  logic          alu_full, mem_full;
  logic [AW-1:0] alu_slot_addr, mem_slot_addr;
  logic [DW-1:0] alu_slot_data, mem_slot_data;
  logic          grant_alu, grant_mem;
  logic          rr;
  logic [RC-1:0] busy_next;
  logic          rsv_hit;

  rf_wb_slot #(.DW(DW), .AW(AW)) u_alu_slot (
    .clk(clk), .rst(rst),
    .in_valid(alu_valid), .in_addr(alu_addr), .in_data(alu_data),
    .grant(grant_alu), .ready(alu_ready), .full(alu_full),
    .addr(alu_slot_addr), .data(alu_slot_data)
  );

  rf_wb_slot #(.DW(DW), .AW(AW)) u_mem_slot (
    .clk(clk), .rst(rst),
    .in_valid(mem_valid), .in_addr(mem_addr), .in_data(mem_data),
    .grant(grant_mem), .ready(mem_ready), .full(mem_full),
    .addr(mem_slot_addr), .data(mem_slot_data)
  );

  // Arbiter: a lone full slot wins; on contention the RR pointer decides.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full && mem_full) begin
      if (rr == SRC_ALU) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else if (alu_full) begin
      grant_alu = 1'b1;
    end else if (mem_full) begin
      grant_mem = 1'b1;
    end else begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
    end
  end

  // RR pointer moves to the loser only after a contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= SRC_ALU;
    end else if (alu_full && mem_full) begin
      rr <= grant_alu ? SRC_MEM : SRC_ALU;
    end else begin
      rr <= rr;
    end
  end

  // Registered RF write port; register 0 consumes its grant but never writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= {AW{1'b0}};
      rf_wdata <= {DW{1'b0}};
    end else if (grant_alu) begin
      rf_wen   <= (alu_slot_addr != {AW{1'b0}});
      rf_waddr <= alu_slot_addr;
      rf_wdata <= alu_slot_data;
    end else if (grant_mem) begin
      rf_wen   <= (mem_slot_addr != {AW{1'b0}});
      rf_waddr <= mem_slot_addr;
      rf_wdata <= mem_slot_data;
    end else begin
      rf_wen   <= 1'b0;
      rf_waddr <= rf_waddr;
      rf_wdata <= rf_wdata;
    end
  end

  // Scoreboard next state: the write on the port clears, a reservation sets (set wins).
  always_comb begin
    busy_next = busy;
    if (rf_wen) begin
      busy_next[rf_waddr] = 1'b0;
    end else begin
      busy_next = busy;
    end
    if (rsv_en && (rsv_addr != {AW{1'b0}})) begin
      busy_next[rsv_addr] = 1'b1;
    end else begin
      busy_next[0] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  // Conflict: reserving a register that is busy and not being written back this edge.
  always_comb begin
    rsv_hit = 1'b0;
    if (rsv_en && (rsv_addr != {AW{1'b0}})) begin
      rsv_hit = busy[rsv_addr] && !(rf_wen && (rf_waddr == rsv_addr));
    end else begin
      rsv_hit = 1'b0;
    end
  end

  // Scoreboard and conflict pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= {RC{1'b0}};
      rsv_conflict <= 1'b0;
    end else begin
      busy         <= busy_next;
      rsv_conflict <= rsv_hit;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed test-plan steps then random traffic, all
// checked against a transaction-level reference model.
module tb_rf_wb_sched;

  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid, rsv_en;
  logic        alu_ready, mem_ready, rsv_conflict;
  logic [3:0]  alu_addr, mem_addr, rsv_addr;
  logic [15:0] alu_data, mem_data;
  logic [15:0] busy;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_sched dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict), .busy(busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two pending entries, a favoured source, and a set of busy registers.
  bit          m_known = 0;
  bit          s_full[2];
  logic [3:0]  s_addr[2];
  logic [15:0] s_data[2];
  int          favour;
  bit          m_busy[16];
  bit          m_wen;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata;
  bit          m_conf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (s_full[0] && s_full[1]) return favour;
    if (s_full[0]) return 0;
    if (s_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_step();
    int w;
    bit rdy[2];
    bit vin[2];
    logic [3:0] ain[2];
    logic [15:0] din[2];
    if (rst) begin
      m_known = 1;
      for (int s = 0; s < 2; s++) begin s_full[s] = 0; s_addr[s] = 4'd0; s_data[s] = 16'd0; end
      for (int i = 0; i < 16; i++) m_busy[i] = 0;
      favour = 0; m_wen = 0; m_waddr = 4'd0; m_wdata = 16'd0; m_conf = 0;
      return;
    end
    vin[0] = alu_valid; ain[0] = alu_addr; din[0] = alu_data;
    vin[1] = mem_valid; ain[1] = mem_addr; din[1] = mem_data;
    w = winner();
    for (int s = 0; s < 2; s++) rdy[s] = !s_full[s] || (w == s);
    if (s_full[0] && s_full[1]) favour = 1 - favour;
    // scoreboard: write on the port releases, reservation claims
    m_conf = 0;
    if (m_wen) m_busy[m_waddr] = 0;
    if (rsv_en && rsv_addr != 4'd0) begin
      m_conf = m_busy[rsv_addr];
      m_busy[rsv_addr] = 1;
    end
    // write port
    if (w >= 0) begin
      m_wen = (s_addr[w] != 4'd0); m_waddr = s_addr[w]; m_wdata = s_data[w];
    end else begin
      m_wen = 0;
    end
    for (int s = 0; s < 2; s++) begin
      if (vin[s] && rdy[s]) begin s_full[s] = 1; s_addr[s] = ain[s]; s_data[s] = din[s]; end
      else if (w == s) s_full[s] = 0;
    end
  endtask

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic cyc();
    int w;
    #1;
    if (m_known && !rst) begin
      w = winner();
      check("alu_ready", alu_ready, (!s_full[0] || w == 0));
      check("mem_ready", mem_ready, (!s_full[1] || w == 1));
    end
    model_step();
    @(posedge clk);
    #1;
    check("rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
    end
    check("busy", busy, busy_vec());
    check("rsv_conflict", rsv_conflict, m_conf);
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; rsv_en = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; rsv_en = 1'b0;
    alu_addr = 4'd0; mem_addr = 4'd0; rsv_addr = 4'd0; alu_data = 16'd0; mem_data = 16'd0;
    @(negedge clk);
    cyc(); cyc();
    idle();
    check("reset_busy", busy, 16'h0000);
    check("reset_wen", rf_wen, 1'b0);
    check("reset_conflict", rsv_conflict, 1'b0);

    // single ALU write to r3
    rsv_en = 1'b1; rsv_addr = 4'd3; cyc(); idle();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234; cyc(); idle();
    cyc();
    check("single_wen", rf_wen, 1'b1);
    check("single_waddr", rf_waddr, 4'd3);
    check("single_wdata", rf_wdata, 16'h1234);
    check("single_busy_set", busy[3], 1'b1);
    cyc();
    check("single_busy_clr", busy[3], 1'b0);

    // contention after reset
    rst = 1'b1; cyc(); idle();
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'hAAAA;
    mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 16'h5555; cyc(); idle();
    cyc();
    check("cont1_first", rf_waddr, 4'd5);
    check("cont1_first_data", rf_wdata, 16'hAAAA);
    cyc();
    check("cont1_second", rf_waddr, 4'd6);
    alu_valid = 1'b1; mem_valid = 1'b1; cyc(); idle();
    cyc();
    check("cont2_first", rf_waddr, 4'd6);
    check("cont2_first_data", rf_wdata, 16'h5555);
    cyc();
    check("cont2_second", rf_waddr, 4'd5);

    // back-to-back ALU stream
    for (int i = 0; i < 5; i++) begin
      alu_valid = (i < 4); alu_addr = 4'(i + 1); alu_data = 16'(16'h0100 + i);
      if (i < 4) begin #1; check("stream_ready", alu_ready, 1'b1); end
      cyc();
      if (i >= 1) begin
        check("stream_wen", rf_wen, 1'b1);
        check("stream_addr", rf_waddr, 4'(i));
      end
    end
    idle(); cyc();
    check("stream_end_wen", rf_wen, 1'b0);

    // write to register 0
    alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF; cyc(); idle();
    cyc();
    check("r0_no_wen", rf_wen, 1'b0);
    check("r0_ready", alu_ready, 1'b1);
    check("r0_busy", busy[0], 1'b0);

    // reservation racing a writeback, then a true conflict
    rsv_en = 1'b1; rsv_addr = 4'd7; cyc(); idle();
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'h0777; cyc(); idle();
    cyc();
    check("r7_port", rf_waddr, 4'd7);
    rsv_en = 1'b1; rsv_addr = 4'd7; cyc(); idle();
    check("r7_busy_kept", busy[7], 1'b1);
    check("r7_no_conflict", rsv_conflict, 1'b0);
    rsv_en = 1'b1; rsv_addr = 4'd7; cyc(); idle();
    check("r7_conflict", rsv_conflict, 1'b1);
    cyc();
    check("r7_conflict_pulse", rsv_conflict, 1'b0);

    // reset with both slots full and busy = 00F0
    rst = 1'b1; cyc(); idle();
    for (int r = 4; r < 8; r++) begin rsv_en = 1'b1; rsv_addr = 4'(r); cyc(); end
    idle();
    check("pre_rst_busy", busy, 16'h00F0);
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 16'h0004;
    mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'h0005; cyc(); idle();
    rst = 1'b1; cyc(); idle();
    check("post_rst_busy", busy, 16'h0000);
    check("post_rst_alu_ready", alu_ready, 1'b1);
    check("post_rst_mem_ready", mem_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("post_rst_no_wen", rf_wen, 1'b0);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      alu_valid = $urandom_range(0, 1);
      mem_valid = $urandom_range(0, 1);
      rsv_en    = $urandom_range(0, 1);
      alu_addr  = 4'($urandom_range(0, 15));
      mem_addr  = 4'($urandom_range(0, 15));
      rsv_addr  = 4'($urandom_range(0, 15));
      alu_data  = 16'($urandom);
      mem_data  = 16'($urandom);
      cyc();
    end
    idle();
    cyc(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Writeback scheduler for the 16x16 register file. It shares the file's single write port between the ALU and load (memory) result paths.
- Each source gets a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains the slots onto registered rf_wen/rf_waddr/rf_wdata.
- It also keeps a 16-bit pending-write scoreboard (busy), which issue logic uses to stall on RAW/WAW hazards.

Parameters:
- DW, 16, data width of writeback values and the RF write port
- AW, 4, register address width; register count is 2**AW

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU slot can accept this cycle
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load slot can accept this cycle
- mem_addr  in  AW  load destination register
- mem_data  in  DW  load result
- rsv_en  in  1  issue reserves a destination this cycle
- rsv_addr  in  AW  register being reserved
- rsv_conflict  out  1  registered pulse: reservation hit an already-busy register
- busy  out  2**AW  pending-write bit per register
- rf_wen  out  1  RF write enable (registered)
- rf_waddr  out  AW  RF write address (registered)
- rf_wdata  out  DW  RF write data (registered)

Behaviour:
- Reset values: rst=1 at an edge clears both slots, busy, rf_wen, rf_waddr, rf_wdata and rsv_conflict to 0. The RR pointer is set to favour ALU. rst has priority over every other event in that cycle.
- Slots: one per source, each holding {full, addr, data}. A handshake (x_valid & x_ready) at an edge loads the slot.
- Ready: x_ready = !x_full | x_grant, where x_grant is this cycle's combinational arbiter decision. This gives one accept per cycle per source, sustained when uncontested.
- Arbitration: only full slots compete.
  - With one full slot, it wins.
  - With both full, the source pointed to by the RR pointer wins. The pointer then moves to the other source; it changes only on a contested grant.
- Write stage: the granted slot drives rf_wen<=1, rf_waddr, rf_wdata at the next edge, and the slot clears unless it is refilled at that same edge.
  - With no grant, rf_wen<=0; rf_waddr and rf_wdata hold their values.
- Latency: handshake at edge E0, earliest grant in the cycle after E0, rf_wen high after E1, RF captures at E2.
- Address 0: the entry is accepted and granted normally, but rf_wen is forced 0. It still consumes the grant and advances RR.
- Scoreboard:
  - busy[a] sets at the edge where rsv_en=1 and rsv_addr=a≠0.
  - busy[a] clears at the edge where the registered rf_wen=1 and rf_waddr=a.
  - A set and a clear of the same address at the same edge leaves the bit set (set wins).
  - busy[0] is constant 0.
- rsv_conflict: goes 1 for one cycle after a reservation to a register whose busy bit is already 1 and is not clearing that edge. busy stays 1 (no count is kept). Issue logic must stall on busy; the conflict output exists for assertion and debug.
- Sources do not check busy. Ordering between the two sources for the same register is issue's responsibility.
- Reset mid-operation: pending slot contents are discarded without any RF write.

Decomposition:
- Shared package: DW and AW defaults, REG_CNT=2**AW, source index constants SRC_ALU=0 and SRC_MEM=1.
- One natural sub-module: rf_wb_slot (holding register with ready/full logic), instantiated twice.
- Arbiter and scoreboard stay in the top level.

Test Plan:
- Reset, then single ALU write: alu_addr=3, data=16'h1234, rsv 3 beforehand → rf_wen=1, waddr=3, wdata=1234 two edges after the handshake; busy[3] 1→0 at the following edge.
- Contention: both slots full with ALU addr 5 = 16'hAAAA and MEM addr 6 = 16'h5555 after reset → ALU writes first, MEM in the next cycle; repeat the contention → MEM is granted first.
- Back-to-back ALU stream of 4 results with mem idle → alu_ready stays 1, and rf_wen is high for 4 consecutive cycles with addresses in order.
- Write to addr 0 with data 16'hFFFF → no rf_wen pulse, alu_ready recovers, busy[0]=0 throughout.
- Reserve r7 in the same cycle that a pending write to r7 is on the registered port → busy[7]=1 afterwards, rsv_conflict=0. Reserve r7 again while busy → rsv_conflict pulses 1 for 1 cycle.
- Assert rst with both slots full and busy=16'h00F0 → no subsequent rf_wen, busy=0, both readies 1 in the cycle after reset.
